// File: rtl/rf_bypass_sb.sv
// Multi-port integer register file with write-to-read bypass and a per-register pending
// scoreboard used by decode to detect RAW hazards on in-flight producers.
module rf_bypass_sb #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumRd     = 2,
  parameter int unsigned NumWr     = 2,
  parameter bit          Bypass    = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumWr-1:0]               wr_en_i,
  input  logic [NumWr*AddrWidth-1:0]     wr_addr_i,
  input  logic [NumWr*DataWidth-1:0]     wr_data_i,
  input  logic [NumRd*AddrWidth-1:0]     rd_addr_i,
  output logic [NumRd*DataWidth-1:0]     rd_data_o,
  output logic [NumRd-1:0]               rd_busy_o,
  input  logic                           rsv_en_i,
  input  logic [AddrWidth-1:0]           rsv_addr_i,
  input  logic                           flush_i
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];
  logic [Depth-1:0]     pend_q, pend_d;

  // Per-register merged write: hit flag and the data of the highest-numbered port.
  logic [Depth-1:0]     wr_hit;
  logic [DataWidth-1:0] wr_val [Depth];
  logic [AddrWidth-1:0] wr_idx;
  logic [AddrWidth-1:0] rd_idx;

  always_comb begin
    wr_hit = '0;
    wr_idx = '0;
    for (int i = 0; i < Depth; i++) begin
      wr_val[i] = '0;
    end
    for (int p = 0; p < NumWr; p++) begin
      wr_idx = wr_addr_i[p*AddrWidth +: AddrWidth];
      if (wr_en_i[p]) begin
        wr_hit[wr_idx] = 1'b1;
        wr_val[wr_idx] = wr_data_i[p*DataWidth +: DataWidth];
      end
    end
    wr_hit[0] = 1'b0;
  end

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < Depth; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_hit[i]) begin
        mem_d[i]  = wr_val[i];
        pend_d[i] = 1'b0;
      end
    end
    // Reserve after write-clear: a same-cycle reservation belongs to a newer producer.
    if (flush_i) begin
      pend_d = '0;
    end else if (rsv_en_i) begin
      pend_d[rsv_addr_i] = 1'b1;
    end
    mem_d[0]  = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Entry 0 is constant zero and never pending, so address 0 needs no special case here.
  always_comb begin
    rd_idx    = '0;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int r = 0; r < NumRd; r++) begin
      rd_idx = rd_addr_i[r*AddrWidth +: AddrWidth];
      rd_data_o[r*DataWidth +: DataWidth] = mem_q[rd_idx];
      rd_busy_o[r] = pend_q[rd_idx];
      if (Bypass && rst_ni && wr_hit[rd_idx]) begin
        rd_data_o[r*DataWidth +: DataWidth] = wr_val[rd_idx];
        rd_busy_o[r] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Directed bench for rf_bypass_sb: one bypassing and one non-bypassing instance driven
// with identical stimulus, each checked against hand-computed values.
module tb_rf_bypass_sb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;

  int n_checks = 0;
  int n_errors = 0;

  rf_bypass_sb #(.Bypass(1'b1)) u_dut_b (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data_b),
    .rd_busy_o (rd_busy_b),
    .rsv_en_i  (rsv_en),
    .rsv_addr_i(rsv_addr),
    .flush_i   (flush)
  );

  rf_bypass_sb #(.Bypass(1'b0)) u_dut_n (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data_n),
    .rd_busy_o (rd_busy_n),
    .rsv_en_i  (rsv_en),
    .rsv_addr_i(rsv_addr),
    .flush_i   (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks read port p on both instances: bypassing (b) and stored-only (n).
  task automatic chk_rd(input string tag, input int p,
                        input logic [31:0] exp_db, input logic exp_bb,
                        input logic [31:0] exp_dn, input logic exp_bn);
    check_eq({tag, " data_b"}, rd_data_b[p*32 +: 32], exp_db);
    check_eq({tag, " busy_b"}, {31'd0, rd_busy_b[p]}, {31'd0, exp_bb});
    check_eq({tag, " data_n"}, rd_data_n[p*32 +: 32], exp_dn);
    check_eq({tag, " busy_n"}, {31'd0, rd_busy_n[p]}, {31'd0, exp_bn});
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*5 +: 5]   = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    flush    = 1'b0;

    // Reset: writes, reserves and bypass are all suppressed.
    set_wr(0, 5'd5, 32'hCAFE_0001);
    rsv_en   = 1'b1;
    rsv_addr = 5'd5;
    set_rd(0, 5'd5);
    set_rd(1, 5'd31);
    #1;
    chk_rd("rst p0", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_rd("rst p1", 1, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    chk_rd("rst edge", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    idle();
    #1;
    chk_rd("rst release", 0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Basic write then read on both ports.
    set_wr(0, 5'd5, 32'hDEAD_BEEF);
    step();
    idle();
    set_rd(0, 5'd5);
    set_rd(1, 5'd5);
    #1;
    chk_rd("r5 p0", 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
    chk_rd("r5 p1", 1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Register 0: writes dropped, never pending, never bypassed.
    set_wr(0, 5'd0, 32'h0000_1234);
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    set_rd(0, 5'd0);
    #1;
    chk_rd("r0 same", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    #1;
    chk_rd("r0 next", 0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Write conflict: port 1 wins.
    set_wr(0, 5'd7, 32'h0000_AAAA);
    set_wr(1, 5'd7, 32'h0000_5555);
    set_rd(0, 5'd7);
    #1;
    chk_rd("r7 same", 0, 32'h0000_5555, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    #1;
    chk_rd("r7 next", 0, 32'h0000_5555, 1'b0, 32'h0000_5555, 1'b0);

    // Reserve, then writeback with and without bypass.
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    set_rd(0, 5'd3);
    #1;
    chk_rd("r3 rsv same", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    #1;
    chk_rd("r3 pending", 0, 32'h0, 1'b1, 32'h0, 1'b1);
    set_wr(1, 5'd3, 32'h0000_0042);
    #1;
    chk_rd("r3 wb same", 0, 32'h0000_0042, 1'b0, 32'h0, 1'b1);
    step();
    idle();
    #1;
    chk_rd("r3 wb next", 0, 32'h0000_0042, 1'b0, 32'h0000_0042, 1'b0);

    // Reserve and write the same register: data lands, pending stays set.
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    set_wr(0, 5'd9, 32'h0000_0099);
    step();
    idle();
    set_rd(0, 5'd9);
    set_rd(1, 5'd10);
    #1;
    chk_rd("r9 rsv+wr", 0, 32'h0000_0099, 1'b1, 32'h0000_0099, 1'b1);
    // Flush beats a same-cycle reserve; a same-cycle write still lands.
    flush    = 1'b1;
    rsv_en   = 1'b1;
    rsv_addr = 5'd10;
    set_wr(1, 5'd31, 32'hFFFF_FFFF);
    step();
    idle();
    #1;
    chk_rd("r9 flush", 0, 32'h0000_0099, 1'b0, 32'h0000_0099, 1'b0);
    chk_rd("r10 flush", 1, 32'h0, 1'b0, 32'h0, 1'b0);
    set_rd(1, 5'd31);
    #1;
    chk_rd("r31 flush wr", 1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);

    // Load state, then assert reset mid-cycle.
    set_wr(0, 5'd11, 32'h0000_1111);
    set_wr(1, 5'd12, 32'h0000_2222);
    rsv_en   = 1'b1;
    rsv_addr = 5'd13;
    step();
    idle();
    set_rd(0, 5'd11);
    set_rd(1, 5'd13);
    #1;
    chk_rd("pre-rst r11", 0, 32'h0000_1111, 1'b0, 32'h0000_1111, 1'b0);
    chk_rd("pre-rst r13", 1, 32'h0, 1'b1, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rd("mid-rst r11", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_rd("mid-rst r13", 1, 32'h0, 1'b0, 32'h0, 1'b0);
    // Activity during reset must be ignored.
    set_wr(0, 5'd11, 32'h0BAD_0BAD);
    rsv_en   = 1'b1;
    rsv_addr = 5'd13;
    #1;
    chk_rd("in-rst wr", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    rst_n = 1'b1;
    #1;
    chk_rd("post-rst r11", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_rd("post-rst r13", 1, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    set_rd(0, 5'd5);
    set_rd(1, 5'd7);
    #1;
    chk_rd("post-rst r5", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_rd("post-rst r7", 1, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
